sl_bus_arbiter: RTL and testbench

//  Downstream consumer of the shared slave output bus driven by message-FIFO slaves (GPIO, etc.).

---
 rtl/sl_bus_arbiter_pkg.sv | 25 ++
 rtl/sl_bus_arbiter_if.sv | 34 +++
 rtl/sl_bus_arbiter_rr.sv | 44 ++++
 rtl/sl_bus_arbiter.sv | 149 ++++++++++++++
 tb/tb_sl_bus_arbiter.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sl_bus_arbiter_pkg.sv
// Shared definitions for the slave-bus arbiter: bus field widths, FSM encodings
// and the registered output beat.
package sl_bus_arbiter_pkg;

  localparam int SL_DATA_WIDTH = 9;
  localparam int SL_BYTE_W     = 8;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SETTLE  = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_LOAD    = 3'd3;
  localparam logic [2:0] ST_HOLD    = 3'd4;
  localparam logic [2:0] ST_RELEASE = 3'd5;

  typedef struct packed {
    logic [SL_BYTE_W-1:0] dat;
    logic                 sof;
    logic                 eof;
  } out_beat_t;

  function automatic logic [SL_BYTE_W-1:0] sl_byte(input logic [SL_DATA_WIDTH-1:0] d);
    return d[SL_BYTE_W-1:0];
  endfunction

endpackage

// File: rtl/sl_bus_arbiter_if.sv
// Shared slave output bus plus the byte stream towards the host TX path.
// master = arbiter side, slave = slaves/sink side.
interface sl_bus_arbiter_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 9
);
  import sl_bus_arbiter_pkg::*;

  logic [NUM_SLAVES-1:0]    sl_arb_request;
  logic [NUM_SLAVES-1:0]    sl_arb_grant;
  logic [ADDR_WIDTH-1:0]    sl_addr;
  logic [SL_DATA_WIDTH-1:0] sl_data;
  logic [ADDR_WIDTH-1:0]    sl_tail;
  logic                     sl_latch_tail;
  logic [SL_BYTE_W-1:0]     out_data;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_sof;
  logic                     out_eof;
  logic                     out_abort;

  modport master (
    input  sl_arb_request, sl_data, sl_tail, out_ready,
    output sl_arb_grant, sl_addr, sl_latch_tail,
           out_data, out_valid, out_sof, out_eof, out_abort
  );

  modport slave (
    output sl_arb_request, sl_data, sl_tail, out_ready,
    input  sl_arb_grant, sl_addr, sl_latch_tail,
           out_data, out_valid, out_sof, out_eof, out_abort
  );

endinterface

// File: rtl/sl_bus_arbiter_rr.sv
// Round-robin picker: one-hot winner is the first request above the last winner,
// combinational from req_i; the pointer only moves when load_i commits a grant.
module sl_bus_arbiter_rr #(
  parameter int NUM_SLAVES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_SLAVES-1:0] req_i,
  input  logic                  load_i,
  output logic [NUM_SLAVES-1:0] win_o,
  output logic                  any_o
);

  localparam int PTR_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d, idx;
  logic             found;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    ptr_d = ptr_q;
    idx   = '0;
    // The last winner is scanned last, so a lone requester still wins.
    for (int i = 1; i <= NUM_SLAVES; i++) begin
      idx = PTR_W'((int'(ptr_q) + i) % NUM_SLAVES);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        win_o[idx] = 1'b1;
        ptr_d      = idx;
      end
    end
    any_o = found;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (load_i && found) begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sl_bus_arbiter.sv
// Grants one slave at a time, streams its frame out at 3 cycles/byte (+3 cycles per frame).
// out_valid/out_data and sl_addr hold while out_ready is low; a dropped request aborts the frame.
module sl_bus_arbiter #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_WIDTH = 9
) (
  input logic              clk,
  input logic              reset,
  sl_bus_arbiter_if.master bus
);
  import sl_bus_arbiter_pkg::*;

  logic [2:0]            state_q, state_d;
  logic [NUM_SLAVES-1:0] grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  out_beat_t             beat_q, beat_d;
  logic                  valid_q, valid_d;
  logic                  latch_q, latch_d;
  logic                  abort_q, abort_d;

  logic [NUM_SLAVES-1:0] win_onehot;
  logic                  win_any;
  logic                  rr_load;
  logic                  req_held;
  logic                  in_frame;
  logic                  last_byte;
  logic                  sl_data_unused;

  sl_bus_arbiter_rr #(.NUM_SLAVES(NUM_SLAVES)) u_rr (
    .clk    (clk),
    .reset  (reset),
    .req_i  (bus.sl_arb_request),
    .load_i (rr_load),
    .win_o  (win_onehot),
    .any_o  (win_any)
  );

  assign req_held  = |(bus.sl_arb_request & grant_q);
  assign in_frame  = state_q inside {ST_SETTLE, ST_FETCH, ST_LOAD, ST_HOLD};
  assign last_byte = (addr_q == len_q - ADDR_WIDTH'(1));
  // Bit 8 of the slave word is slave-side metadata that this path does not forward.
  assign sl_data_unused = bus.sl_data[SL_DATA_WIDTH-1];

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    len_d   = len_q;
    beat_d  = beat_q;
    valid_d = valid_q;
    latch_d = 1'b0;
    abort_d = 1'b0;
    rr_load = 1'b0;

    if (in_frame && !req_held) begin
      abort_d = 1'b1;
      valid_d = 1'b0;
      grant_d = '0;
      addr_d  = '0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (win_any) begin
            grant_d = win_onehot;
            rr_load = 1'b1;
            state_d = ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // Bus has had one turnaround cycle; the granted slave now drives sl_tail.
          len_d = bus.sl_tail;
          if (bus.sl_tail == '0) begin
            latch_d = 1'b1;
            state_d = ST_RELEASE;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_FETCH: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          beat_d.dat = sl_byte(bus.sl_data);
          beat_d.sof = (addr_q == '0);
          beat_d.eof = last_byte;
          valid_d    = 1'b1;
          state_d    = ST_HOLD;
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            valid_d = 1'b0;
            if (last_byte) begin
              latch_d = 1'b1;
              state_d = ST_RELEASE;
            end else begin
              addr_d  = addr_q + ADDR_WIDTH'(1);
              state_d = ST_FETCH;
            end
          end
        end
        ST_RELEASE: begin
          grant_d = '0;
          addr_d  = '0;
          state_d = ST_IDLE;
        end
        default: begin
          grant_d = '0;
          addr_d  = '0;
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      beat_q  <= '0;
      valid_q <= 1'b0;
      latch_q <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      valid_q <= valid_d;
      latch_q <= latch_d;
      abort_q <= abort_d;
    end
  end

  assign bus.sl_arb_grant  = grant_q;
  assign bus.sl_addr       = addr_q;
  assign bus.sl_latch_tail = latch_q;
  assign bus.out_data      = beat_q.dat;
  assign bus.out_valid     = valid_q;
  assign bus.out_sof       = beat_q.sof & valid_q;
  assign bus.out_eof       = beat_q.eof & valid_q;
  assign bus.out_abort     = abort_q;

endmodule

// File: tb/tb_sl_bus_arbiter.sv
// Bench for sl_bus_arbiter: slave frame stores, per-slave expected-beat queues,
// a round-robin reference and a negedge monitor that checks every DUT event.
module tb_sl_bus_arbiter;
  import sl_bus_arbiter_pkg::*;

  localparam int NS = 4;
  localparam int AW = 9;

  typedef struct { int base; int len; } frame_t;
  typedef struct { logic [7:0] dat; logic sof; logic eof; } beat_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sl_bus_arbiter_if #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW)) bus ();

  sl_bus_arbiter #(.NUM_SLAVES(NS), .ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [7:0] mem[$];
  logic [7:0] src[$];
  frame_t     sq[NS][$];
  beat_t      exp_q[NS][$];
  beat_t      infl[NS][$];
  int         gnt_log[$];

  int total = 0;
  int bad = 0;
  int cyc = 0, last_hs = 0, grant_cyc = 0, rr_last = 0;
  int abort_pending = 0, abort_count = 0, abort_slave = -1, abort_at = 0;
  int stall_run = 0, max_stall = 0, stall_left = 0;
  int ready_mode = 3;
  bit tput_check = 0, stall_arm = 0, latch_chk = 0, valid_seen = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int oh_idx(input int v);
    for (int i = 0; i < NS; i++) if (v == (1 << i)) return i;
    return -1;
  endfunction

  // First requester strictly after the previous winner, wrapping around.
  function automatic int rr_pick(input int req, input int last);
    for (int d = 1; d <= NS; d++) begin
      int k;
      k = (last + d) % NS;
      if (((req >> k) & 1) == 1) return k;
    end
    return -1;
  endfunction

  function automatic int pending();
    int n;
    n = abort_pending;
    for (int s = 0; s < NS; s++) n += sq[s].size() + exp_q[s].size();
    return n;
  endfunction

  task automatic enq(input int s, input int n);
    frame_t f;
    logic [7:0] b;
    f.base = mem.size();
    f.len  = n;
    for (int i = 0; i < n; i++) begin
      if (src.size() > 0) b = src.pop_front();
      else b = 8'($urandom);
      mem.push_back(b);
      exp_q[s].push_back('{dat: b, sof: (i == 0), eof: (i == n - 1)});
    end
    sq[s].push_back(f);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_", name}, pending(), 0);
    repeat (3) @(negedge clk);
  endtask

  // Slaves: request while a frame is pending; 1-cycle registered read of sl_addr.
  initial begin : slave_model
    int addr_n, gn, s, s2;
    logic [NS-1:0] r;
    forever begin
      @(negedge clk);
      addr_n = int'(bus.sl_addr);
      gn     = int'(bus.sl_arb_grant);
      @(posedge clk);
      #1;
      r = '0;
      for (int k = 0; k < NS; k++) if (sq[k].size() > 0) r = r | (NS'(1) << k);
      bus.sl_arb_request = r;
      s = oh_idx(gn);
      if (s >= 0 && sq[s].size() > 0 && addr_n < sq[s][0].len)
        bus.sl_data = {1'($urandom), mem[sq[s][0].base + addr_n]};
      else
        bus.sl_data = 9'($urandom);
      s2 = oh_idx(int'(bus.sl_arb_grant));
      if (s2 >= 0 && sq[s2].size() > 0) bus.sl_tail = AW'(sq[s2][0].len);
      else bus.sl_tail = AW'($urandom);
    end
  end

  initial begin : ready_model
    int s;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: begin
          s = oh_idx(int'(bus.sl_arb_grant));
          if (stall_left > 0) begin
            bus.out_ready = 1'b0;
            stall_left--;
          end else if (stall_arm && bus.out_valid && s >= 0 && infl[s].size() == 2) begin
            bus.out_ready = 1'b0;
            stall_left = 9;
            stall_arm = 0;
          end else begin
            bus.out_ready = 1'b1;
          end
        end
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  initial begin : monitor
    int g, s, prev_grant;
    bit ok, prev_valid, prev_ready;
    logic [7:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic [NS-1:0] prev_req;
    beat_t e;
    frame_t f;
    prev_grant = 0; prev_valid = 0; prev_ready = 0; prev_req = '0;
    prev_data = '0; prev_addr = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_grant = 0;
        prev_valid = 0;
        latch_chk  = 0;
      end else begin
        g = int'(bus.sl_arb_grant);
        s = oh_idx(g);
        chk("grant_onehot0", int'($countones(bus.sl_arb_grant) <= 1), 1);
        if (latch_chk) begin
          chk("grant_low_after_latch", g, 0);
          latch_chk = 0;
        end
        if (prev_grant == 0 && g != 0) begin
          int w;
          w = rr_pick(int'(prev_req), rr_last);
          chk("rr_winner", s, w);
          if (w >= 0) rr_last = w;
          grant_cyc  = cyc;
          valid_seen = 0;
          gnt_log.push_back(s);
        end
        if (bus.out_valid) valid_seen = 1;
        if (prev_valid && !prev_ready) begin
          chk("stall_valid", bus.out_valid, 1);
          chk("stall_data", bus.out_data, prev_data);
          chk("stall_addr", bus.sl_addr, prev_addr);
        end
        if (bus.out_valid && !bus.out_ready) begin
          stall_run++;
          if (stall_run > max_stall) max_stall = stall_run;
        end else begin
          stall_run = 0;
        end
        if (bus.out_valid && bus.out_ready) begin
          ok = (s >= 0) && (exp_q[s].size() > 0);
          chk("beat_owner", ok, 1);
          if (ok) begin
            e = exp_q[s].pop_front();
            chk("beat_data", bus.out_data, e.dat);
            chk("beat_sof", bus.out_sof, e.sof);
            chk("beat_eof", bus.out_eof, e.eof);
            if (tput_check && infl[s].size() > 0) chk("byte_spacing", cyc - last_hs, 3);
            infl[s].push_back(e);
            last_hs = cyc;
            if (s == abort_slave && infl[s].size() == abort_at) begin
              f = sq[s].pop_front();
              for (int k = abort_at; k < f.len; k++) exp_q[s].delete(0);
              infl[s].delete();
              abort_pending = 1;
              abort_slave = -1;
            end
          end
        end
        if (bus.sl_latch_tail) begin
          ok = (s >= 0) && (sq[s].size() > 0);
          chk("latch_has_frame", ok, 1);
          if (ok) begin
            f = sq[s][0];
            chk("latch_all_bytes", infl[s].size(), f.len);
            if (f.len == 0) begin
              chk("empty_latch_delay", cyc - grant_cyc, 1);
              chk("empty_no_valid", valid_seen, 0);
            end else begin
              chk("latch_after_last", cyc - last_hs, 1);
            end
            sq[s].delete(0);
            infl[s].delete();
          end
          latch_chk = 1;
        end
        if (bus.out_abort) begin
          chk("abort_expected", abort_pending, 1);
          chk("abort_grant_low", g, 0);
          chk("abort_valid_low", bus.out_valid, 0);
          abort_pending = 0;
          abort_count++;
        end
        prev_grant = g;
        prev_valid = bus.out_valid;
        prev_ready = bus.out_ready;
        prev_data  = bus.out_data;
        prev_addr  = bus.sl_addr;
      end
      prev_req = bus.sl_arb_request;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run still active at t=%0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int base, n;
    reset = 1'b1;
    bus.sl_arb_request = '0;
    bus.sl_data = '0;
    bus.sl_tail = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_grant", bus.sl_arb_grant, 0);
    chk("rst_addr", bus.sl_addr, 0);
    chk("rst_latch", bus.sl_latch_tail, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_sof", bus.out_sof, 0);
    chk("rst_eof", bus.out_eof, 0);
    chk("rst_abort", bus.out_abort, 0);
    #2 reset = 1'b0;

    // Single frame, sink always ready.
    ready_mode = 0;
    tput_check = 1;
    src = {8'h67, 8'h05, 8'h03, 8'h6C, 8'hAA, 8'hBB, 8'hCC};
    enq(0, 7);
    drain("single", 500);
    tput_check = 0;

    // Simultaneous requests from slaves 0 and 2 with the pointer on 0.
    base = gnt_log.size();
    enq(0, 3);
    enq(2, 4);
    drain("pair", 500);
    chk("rr_first", (gnt_log.size() > base) ? gnt_log[base] : -1, 2);
    chk("rr_second", (gnt_log.size() > base + 1) ? gnt_log[base + 1] : -1, 0);

    // Sink stalls 10 cycles on the third byte.
    ready_mode = 2;
    stall_arm = 1;
    max_stall = 0;
    enq(1, 6);
    drain("stall", 500);
    chk("stall_len", max_stall, 10);
    ready_mode = 0;

    // Empty frame.
    enq(3, 0);
    drain("empty", 200);

    // Slave withdraws its request after two bytes.
    abort_slave = 1;
    abort_at = 2;
    enq(1, 5);
    drain("abort", 500);
    chk("abort_count", abort_count, 1);

    // Reset while a byte is held, then the frame replays from the start.
    ready_mode = 3;
    enq(2, 4);
    n = 0;
    while (!bus.out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reach_hold", bus.out_valid, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_grant", bus.sl_arb_grant, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_addr", bus.sl_addr, 0);
    chk("mid_rst_latch", bus.sl_latch_tail, 0);
    for (int s = 0; s < NS; s++)
      while (infl[s].size() > 0) exp_q[s].push_front(infl[s].pop_back());
    rr_last = 0;
    @(negedge clk);
    #2 reset = 1'b0;
    ready_mode = 0;
    drain("replay", 500);

    // Random traffic with a random sink.
    ready_mode = 1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk);
      #2;
      if ($urandom_range(0, 5) == 0) enq(int'($urandom_range(0, NS - 1)), int'($urandom_range(0, 6)));
    end
    drain("random", 8000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
